// File: rtl/knight_sprite_animator.sv
// Knight sprite animator: latches player state once per frame, sequences animation
// frames, and per pixel produces a registered hit flag and sprite-sheet ROM address.
module knight_sprite_animator #(
    parameter int SPRITE_W   = 30,
    parameter int SPRITE_H   = 62,
    parameter int FRAME_HOLD = 6,
    parameter int IDLE_N     = 4,
    parameter int WALK_N     = 6,
    parameter int RISE_N     = 2,
    parameter int FALL_N     = 2,
    parameter int ADDR_W     = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vs,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    input  logic [3:0]        Player_Status,
    input  logic              Inverse,
    output logic              is_knight,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic [2:0]        anim_frame
);

    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

    typedef enum logic [1:0] {IDLE, WALK, RISE, FALL} state_t;

    state_t            state_reg, state_next, status_in;
    logic              vs_d_reg;
    logic              fp;
    logic [9:0]        x_reg, y_reg;
    logic              inv_reg;
    logic [2:0]        frame_reg, frame_next, frame_last;
    logic [7:0]        hold_reg, hold_next;
    logic [9:0]        left, top, col, row, mcol;
    logic              hit;
    logic [ADDR_W-1:0] base, addr_next;

    assign fp         = vs_d_reg & ~vs;
    assign anim_frame = frame_reg;

    always_comb begin
        case (Player_Status)
            4'd1:    status_in = WALK;
            4'd2:    status_in = RISE;
            4'd3:    status_in = FALL;
            default: status_in = IDLE;
        endcase
    end

    always_comb begin
        frame_last = 3'(IDLE_N - 1);
        base       = '0;
        case (state_reg)
            WALK: begin
                frame_last = 3'(WALK_N - 1);
                base       = ADDR_W'(IDLE_N * FRAME_WORDS);
            end
            RISE: begin
                frame_last = 3'(RISE_N - 1);
                base       = ADDR_W'((IDLE_N + WALK_N) * FRAME_WORDS);
            end
            FALL: begin
                frame_last = 3'(FALL_N - 1);
                base       = ADDR_W'((IDLE_N + WALK_N + RISE_N) * FRAME_WORDS);
            end
            default: ;
        endcase
    end

    // A status change restarts the animation even if the hold counter was about to expire.
    always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        hold_next  = hold_reg;
        if (fp) begin
            state_next = status_in;
            if (status_in != state_reg) begin
                frame_next = '0;
                hold_next  = '0;
            end else if (hold_reg == 8'(FRAME_HOLD - 1)) begin
                hold_next = '0;
                if (frame_reg != frame_last)
                    frame_next = frame_reg + 3'd1;
                else if (state_reg == IDLE || state_reg == WALK)
                    frame_next = '0;
            end else begin
                hold_next = hold_reg + 8'd1;
            end
        end
    end

    // Modulo-1024 differences let boxes hanging off the left/top edge still match.
    always_comb begin
        left = x_reg - 10'(SPRITE_W / 2);
        top  = y_reg - 10'(SPRITE_H / 2);
        col  = DrawX - left;
        row  = DrawY - top;
        hit  = (col < 10'(SPRITE_W)) && (row < 10'(SPRITE_H));
        mcol = inv_reg ? (10'(SPRITE_W - 1) - col) : col;
        addr_next = '0;
        if (hit)
            addr_next = base
                      + ADDR_W'(frame_reg) * ADDR_W'(FRAME_WORDS)
                      + ADDR_W'(row) * ADDR_W'(SPRITE_W)
                      + ADDR_W'(mcol);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_d_reg    <= 1'b1;
            x_reg       <= 10'd320;
            y_reg       <= 10'd377;
            inv_reg     <= 1'b0;
            state_reg   <= IDLE;
            frame_reg   <= '0;
            hold_reg    <= '0;
            is_knight   <= 1'b0;
            sprite_addr <= '0;
        end else begin
            vs_d_reg  <= vs;
            state_reg <= state_next;
            frame_reg <= frame_next;
            hold_reg  <= hold_next;
            if (fp) begin
                x_reg   <= PlayerX;
                y_reg   <= PlayerY;
                inv_reg <= Inverse;
            end
            is_knight   <= hit;
            sprite_addr <= addr_next;
        end
    end

endmodule

// File: tb/tb_knight_sprite_animator.sv
// Bench for knight_sprite_animator: frame-count based reference model checked every
// cycle, plus directed pixel probes with hand-computed addresses.
module tb_knight_sprite_animator;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic [9:0]  draw_x, draw_y, player_x, player_y;
    logic [3:0]  player_status;
    logic        inverse;
    logic        is_knight;
    logic [14:0] sprite_addr;
    logic [2:0]  anim_frame;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: k = frame pulses since the last status change
    logic        m_vs_d;
    int          m_x, m_y, m_st, m_k;
    logic        m_inv;
    logic [15:0] exp_pkt;

    knight_sprite_animator dut (
        .Clk(clk), .Reset(rst), .vs(vs),
        .DrawX(draw_x), .DrawY(draw_y),
        .PlayerX(player_x), .PlayerY(player_y),
        .Player_Status(player_status), .Inverse(inverse),
        .is_knight(is_knight), .sprite_addr(sprite_addr), .anim_frame(anim_frame)
    );

    always #5 clk = ~clk;

    function automatic int frame_of(int st, int k);
        int n;
        int f;
        n = (st == 1) ? 6 : ((st == 2 || st == 3) ? 2 : 4);
        f = k / 6;
        if (st == 0 || st == 1) return f % n;
        return (f > n - 1) ? n - 1 : f;
    endfunction

    function automatic logic [15:0] pix_model(int dx, int dy, int x, int y, int st, int k, logic inv);
        int first_frame [4];
        int col, row, mc, a;
        first_frame = '{0, 4, 10, 12};
        col = (dx - ((x - 15) & 1023)) & 1023;
        row = (dy - ((y - 31) & 1023)) & 1023;
        if (col >= 30 || row >= 62) return 16'd0;
        mc = inv ? 29 - col : col;
        a  = (first_frame[st] + frame_of(st, k)) * 1860 + row * 30 + mc;
        return {1'b1, 15'(a)};
    endfunction

    function automatic int map_st(logic [3:0] s);
        return (s < 4) ? int'(s) : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vs_d  <= 1'b1;
            m_x     <= 320;
            m_y     <= 377;
            m_st    <= 0;
            m_k     <= 0;
            m_inv   <= 1'b0;
            exp_pkt <= 16'd0;
        end else begin
            m_vs_d  <= vs;
            exp_pkt <= pix_model(int'(draw_x), int'(draw_y), m_x, m_y, m_st, m_k, m_inv);
            if (m_vs_d && !vs) begin
                m_x   <= int'(player_x);
                m_y   <= int'(player_y);
                m_inv <= inverse;
                m_st  <= map_st(player_status);
                m_k   <= (map_st(player_status) != m_st) ? 0 : m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (is_knight !== exp_pkt[15] || sprite_addr !== exp_pkt[14:0]
                || anim_frame !== 3'(frame_of(m_st, m_k))) begin
                miscompares++;
                $display("FAIL model t=%0t hit=%0b/%0b addr=%0d/%0d frame=%0d/%0d (actual/required)",
                         $time, is_knight, exp_pkt[15], sprite_addr, exp_pkt[14:0],
                         anim_frame, frame_of(m_st, m_k));
            end
        end
    end

    task automatic check(string name, int actual, int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end else begin
            $display("ok   %s = %0d", name, actual);
        end
    endtask

    task automatic frame_pulse();
        vs = 1'b0;
        @(posedge clk); #2;
        vs = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic pix(string name, int dx, int dy, int hit, int addr);
        draw_x = 10'(dx);
        draw_y = 10'(dy);
        @(posedge clk); #2;
        check({name, ".hit"}, int'(is_knight), hit);
        check({name, ".addr"}, int'(sprite_addr), addr);
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1;
        draw_x = '0; draw_y = '0;
        player_x = 10'd320; player_y = 10'd377; player_status = 4'd0; inverse = 1'b0;
        #1;
        check("reset.hit", int'(is_knight), 0);
        check("reset.addr", int'(sprite_addr), 0);
        check("reset.frame", int'(anim_frame), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        frame_pulse();
        pix("topleft", 305, 346, 1, 0);
        pix("botright", 334, 407, 1, 1859);
        pix("left_out", 304, 346, 0, 0);
        pix("below_out", 305, 408, 0, 0);

        inverse = 1'b1;
        frame_pulse();
        pix("mirror_l", 305, 346, 1, 29);
        pix("mirror_r", 334, 346, 1, 0);

        inverse = 1'b0; player_status = 4'd1;
        frame_pulse();
        repeat (6) frame_pulse();
        check("walk6.frame", int'(anim_frame), 1);
        pix("walk6", 305, 346, 1, 9300);
        repeat (30) frame_pulse();
        check("walk36.frame", int'(anim_frame), 0);

        player_status = 4'd2;
        frame_pulse();
        repeat (30) frame_pulse();
        check("rise_sat.frame", int'(anim_frame), 1);
        pix("rise_sat", 305, 346, 1, 20460);
        player_status = 4'd3;
        frame_pulse();
        check("fall.frame", int'(anim_frame), 0);
        pix("fall", 305, 346, 1, 22320);

        player_status = 4'd0; player_x = 10'd10;
        frame_pulse();
        pix("wrap_in", 0, 346, 1, 5);
        pix("wrap_out", 639, 346, 0, 0);

        player_x = 10'd200; inverse = 1'b1; player_status = 4'd1;
        repeat (3) @(posedge clk);
        #2;
        pix("no_fp", 0, 346, 1, 5);
        check("no_fp.frame", int'(anim_frame), 0);

        frame_pulse();
        repeat (6) frame_pulse();
        pix("walk_mirror", 185, 346, 1, 9329);
        rst = 1'b1;
        #1;
        check("midreset.hit", int'(is_knight), 0);
        check("midreset.frame", int'(anim_frame), 0);
        check("midreset.addr", int'(sprite_addr), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        pix("after_reset", 305, 346, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
